// File: rtl/dmem_lsu_if.sv
// Pipeline-side load/store handshake between the MEM stage (master) and dmem_lsu (slave).
interface dmem_lsu_if;
    logic        mem_req;
    logic        mem_we;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_busy;
    logic        mem_done;
    logic        mem_err;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_op, mem_addr, mem_wdata,
        input  mem_busy, mem_done, mem_err, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_op, mem_addr, mem_wdata,
        output mem_busy, mem_done, mem_err, mem_rdata
    );
endinterface

// File: rtl/dmem_lsu.sv
// MEM-stage load/store unit: byte/half/word accesses onto a word-wide data memory, sub-word stores by RMW.
// Optional LSU_BOUNDS_CHECK_EN: reject byte addresses above the 2**(ADDR_W+2) window instead of wrapping.
module dmem_lsu #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_lsu_if.slave         bus,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic              dm_we,
    input  logic [31:0]       dm_rdata
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WRITE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    logic [1:0]        state;
    logic              we_q;
    logic [2:0]        op_q;
    logic [1:0]        lane_q;
    logic [15:0]       wdata_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] dm_addr_q;
    logic [31:0]       dm_wdata_q;

    logic              req_err;
    logic [15:0]       lane_half;
    logic [7:0]        lane_byte;
    logic [31:0]       load_val;
    logic [31:0]       lane_mask;
    logic [31:0]       lane_ins;
    logic [31:0]       merged;

    always_comb begin
        req_err = 1'b0;
        case (bus.mem_op)
            OP_B:    req_err = 1'b0;
            OP_H:    req_err = bus.mem_addr[0];
            OP_W:    req_err = |bus.mem_addr[1:0];
            OP_BU:   req_err = bus.mem_we;
            OP_HU:   req_err = bus.mem_we | bus.mem_addr[0];
            default: req_err = 1'b1;
        endcase
`ifdef LSU_BOUNDS_CHECK_EN
        if (|bus.mem_addr[31:ADDR_W+2]) begin
            req_err = 1'b1;
        end
`endif
    end

`ifndef LSU_BOUNDS_CHECK_EN
    // Upper byte-address bits simply wrap; they have no reader in this build.
    logic unused_upper_addr;
    assign unused_upper_addr = ^bus.mem_addr[31:ADDR_W+2];
`endif

    always_comb begin
        lane_half = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        lane_byte = lane_q[0] ? lane_half[15:8] : lane_half[7:0];
        case (op_q)
            OP_B:    load_val = {{24{lane_byte[7]}}, lane_byte};
            OP_BU:   load_val = {24'h000000, lane_byte};
            OP_H:    load_val = {{16{lane_half[15]}}, lane_half};
            OP_HU:   load_val = {16'h0000, lane_half};
            default: load_val = dm_rdata;
        endcase
    end

    // Sub-word store: replicate the store data across all lanes, then keep only the addressed lane.
    always_comb begin
        if (op_q[0]) begin
            lane_mask = lane_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
            lane_ins  = {2{wdata_q}};
        end else begin
            lane_mask = 32'h0000_00FF << {lane_q, 3'b000};
            lane_ins  = {4{wdata_q[7:0]}};
        end
        merged = (dm_rdata & ~lane_mask) | (lane_ins & lane_mask);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            op_q       <= 3'b000;
            lane_q     <= 2'b00;
            wdata_q    <= 16'h0000;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            dm_addr_q  <= '0;
            dm_wdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_req) begin
                        we_q    <= bus.mem_we;
                        op_q    <= bus.mem_op;
                        lane_q  <= bus.mem_addr[1:0];
                        wdata_q <= bus.mem_wdata[15:0];
                        err_q   <= req_err;
                        if (req_err) begin
                            rdata_q <= 32'h0;
                            state   <= RESP;
                        end else begin
                            dm_addr_q <= bus.mem_addr[ADDR_W+1:2];
                            if (bus.mem_we && bus.mem_op == OP_W) begin
                                dm_wdata_q <= bus.mem_wdata;
                            end
                            state <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_val;
                        state   <= RESP;
                    end else if (op_q == OP_W) begin
                        state <= RESP;
                    end else begin
                        dm_wdata_q <= merged;
                        state      <= WRITE;
                    end
                end
                WRITE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Write enable depends only on state so it is stable from posedge through the memory's negedge commit.
    assign dm_we         = (state == WRITE) || (state == ACCESS && we_q && op_q == OP_W);
    assign dm_addr       = dm_addr_q;
    assign dm_wdata      = dm_wdata_q;
    assign bus.mem_busy  = (state != IDLE);
    assign bus.mem_done  = (state == RESP);
    assign bus.mem_err   = (state == RESP) && err_q;
    assign bus.mem_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomized self-checking bench for dmem_lsu against a transaction-level model of the memory and LSU.
module tb_dmem_lsu;

    localparam int ADDR_W = 11;
    localparam int NWORDS = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_we;
    logic [31:0]       dm_rdata;

    dmem_lsu_if bus ();

    dmem_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_we    (dm_we),
        .dm_rdata (dm_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [0:NWORDS-1];
    logic [31:0] ref_mem [0:NWORDS-1];

    assign dm_rdata = mem[dm_addr];

    always @(negedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_wdata;
    end

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_rdata_hold = 32'h0;
    int          last_lat;
    logic        last_err;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: what one request must produce, from the op/address rules alone.
    task automatic modelRequest(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                                output int lat, output int widx, output logic [31:0] new_word,
                                output int writes);
        int          size;
        int          sh;
        logic [31:0] old;
        logic [31:0] raw;
        logic [31:0] mask;
        logic        legal;
        legal = (op == 3'd0 || op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5);
        size  = (op == 3'd2) ? 4 : (op[0] ? 2 : 1);
        widx  = int'((addr >> 2) % NWORDS);
        sh    = int'(addr % 4) * 8;
        old   = ref_mem[widx];
        err   = !legal || (we && op[2]) || ((addr % size) != 0);
`ifdef LSU_BOUNDS_CHECK_EN
        if ((addr >> (ADDR_W + 2)) != 0) err = 1'b1;
`endif
        new_word = old;
        writes   = 0;
        rdata    = exp_rdata_hold;
        if (err) begin
            rdata = 32'h0;
            lat   = 1;
        end else if (!we) begin
            raw = old >> sh;
            if (size == 1) begin
                rdata = raw & 32'hFF;
                if (!op[2] && rdata[7]) rdata = rdata | 32'hFFFF_FF00;
            end else if (size == 2) begin
                rdata = raw & 32'hFFFF;
                if (!op[2] && rdata[15]) rdata = rdata | 32'hFFFF_0000;
            end else begin
                rdata = old;
            end
            lat = 2;
        end else begin
            mask     = (size == 4) ? 32'hFFFF_FFFF : (((32'h1 << (8 * size)) - 32'h1) << sh);
            new_word = (old & ~mask) | ((wdata << sh) & mask);
            writes   = 1;
            lat      = (size == 4) ? 2 : 3;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata);
        logic        e_err;
        logic [31:0] e_rdata;
        logic [31:0] e_word;
        int          e_lat;
        int          widx;
        int          e_writes;
        int          we_cnt;
        int          we_at;
        int          seen_lat;
        logic        done_seen;
        modelRequest(we, op, addr, wdata, e_err, e_rdata, e_lat, widx, e_word, e_writes);
        @(negedge clk);
        checkOutput("idle_busy", {31'b0, bus.mem_busy}, 32'd0);
        bus.mem_req   = 1'b1;
        bus.mem_we    = we;
        bus.mem_op    = op;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        @(posedge clk);
        done_seen = 1'b0;
        we_cnt    = 0;
        we_at     = 0;
        seen_lat  = 0;
        for (int n = 1; n <= 8 && !done_seen; n++) begin
            @(negedge clk);
            if (dm_we) begin
                we_cnt++;
                we_at = n;
                checkOutput("we_addr", 32'(dm_addr), 32'(widx));
                checkOutput("we_data", dm_wdata, e_word);
            end
            if (bus.mem_done) begin
                done_seen = 1'b1;
                seen_lat  = n;
            end else begin
                checkOutput("busy", {31'b0, bus.mem_busy}, 32'd1);
                bus.mem_req   = 1'($urandom_range(0, 1));
                bus.mem_we    = 1'($urandom_range(0, 1));
                bus.mem_op    = 3'($urandom_range(0, 7));
                bus.mem_addr  = $urandom;
                bus.mem_wdata = $urandom;
            end
        end
        bus.mem_req = 1'b0;
        if (!done_seen) begin
            checkOutput("done_timeout", {31'b0, bus.mem_done}, 32'd1);
        end else begin
            checkOutput("latency", 32'(seen_lat), 32'(e_lat));
            checkOutput("done_busy", {31'b0, bus.mem_busy}, 32'd1);
            checkOutput("err", {31'b0, bus.mem_err}, {31'b0, e_err});
            checkOutput("rdata", bus.mem_rdata, e_rdata);
            checkOutput("we_count", 32'(we_cnt), 32'(e_writes));
            if (e_writes != 0) checkOutput("we_cycle", 32'(we_at), 32'(e_lat - 1));
            checkOutput("mem_word", mem[widx], e_word);
        end
        ref_mem[widx]  = e_word;
        exp_rdata_hold = e_rdata;
        last_lat       = seen_lat;
        last_err       = bus.mem_err;
    endtask

    initial begin
        logic [31:0] word0;
        logic [31:0] addr;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_op    = 3'b000;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", {31'b0, bus.mem_busy}, 32'd0);
        checkOutput("rst_done", {31'b0, bus.mem_done}, 32'd0);
        checkOutput("rst_err", {31'b0, bus.mem_err}, 32'd0);
        checkOutput("rst_rdata", bus.mem_rdata, 32'h0);
        checkOutput("rst_dm_we", {31'b0, dm_we}, 32'd0);
        checkOutput("rst_dm_addr", 32'(dm_addr), 32'h0);
        checkOutput("rst_dm_wdata", dm_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 3'd2, 32'(i * 4), $urandom);

        applyStimulus(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        checkOutput("lit_sw_lat", 32'(last_lat), 32'd2);
        applyStimulus(1'b0, 3'd2, 32'h10, 32'h0);
        checkOutput("lit_lw", bus.mem_rdata, 32'hDEAD_BEEF);
        checkOutput("lit_lw_lat", 32'(last_lat), 32'd2);

        applyStimulus(1'b1, 3'd2, 32'h20, 32'h1122_3344);
        applyStimulus(1'b0, 3'd0, 32'h23, 32'h0);
        checkOutput("lit_lb23", bus.mem_rdata, 32'h0000_0011);
        applyStimulus(1'b0, 3'd1, 32'h22, 32'h0);
        checkOutput("lit_lh22", bus.mem_rdata, 32'h0000_1122);
        applyStimulus(1'b1, 3'd0, 32'h21, 32'h0000_0080);
        checkOutput("lit_sb_word", mem[8], 32'h1122_8044);
        applyStimulus(1'b0, 3'd0, 32'h21, 32'h0);
        checkOutput("lit_lb21", bus.mem_rdata, 32'hFFFF_FF80);
        applyStimulus(1'b0, 3'd4, 32'h21, 32'h0);
        checkOutput("lit_lbu21", bus.mem_rdata, 32'h0000_0080);

        applyStimulus(1'b1, 3'd2, 32'h20, 32'h1122_3344);
        applyStimulus(1'b1, 3'd1, 32'h22, 32'h0000_ABCD);
        checkOutput("lit_sh_word", mem[8], 32'hABCD_3344);
        checkOutput("lit_sh_lat", 32'(last_lat), 32'd3);

        applyStimulus(1'b0, 3'd2, 32'h02, 32'h0);
        checkOutput("lit_lw_mis_err", {31'b0, last_err}, 32'd1);
        checkOutput("lit_lw_mis_rdata", bus.mem_rdata, 32'h0);
        applyStimulus(1'b1, 3'd1, 32'h01, 32'h0000_5555);
        checkOutput("lit_sh_mis_err", {31'b0, last_err}, 32'd1);
        applyStimulus(1'b0, 3'd3, 32'h30, 32'h0);
        checkOutput("lit_op3_err", {31'b0, last_err}, 32'd1);

        word0 = mem[0];
        applyStimulus(1'b1, 3'd2, 32'h0000_2000, 32'hCAFE_F00D);
`ifdef LSU_BOUNDS_CHECK_EN
        checkOutput("lit_oob_err", {31'b0, last_err}, 32'd1);
        checkOutput("lit_oob_word", mem[0], word0);
`else
        checkOutput("lit_wrap_err", {31'b0, last_err}, 32'd0);
        checkOutput("lit_wrap_word", mem[0], 32'hCAFE_F00D);
`endif

        // Reset in the WRITE cycle of an SB must suppress the negedge commit and drop the request.
        applyStimulus(1'b1, 3'd2, 32'h40, 32'h5566_7788);
        @(negedge clk);
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_op    = 3'd0;
        bus.mem_addr  = 32'h41;
        bus.mem_wdata = 32'h12;
        @(posedge clk);
        @(negedge clk);
        bus.mem_req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_we_before", {31'b0, dm_we}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_we", {31'b0, dm_we}, 32'd0);
        checkOutput("rst_mid_busy", {31'b0, bus.mem_busy}, 32'd0);
        checkOutput("rst_mid_done", {31'b0, bus.mem_done}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_mid_word", mem[16], 32'h5566_7788);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata_hold = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_mid_no_done", {31'b0, bus.mem_done}, 32'd0);
        end

        for (int i = 0; i < 300; i++) begin
            logic [2:0]  op;
            logic [31:0] lane;
            lane = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(0, 3));
            op   = 3'($urandom_range(0, 7));
            addr = (32'($urandom_range(0, 31)) << 2) | lane;
            if ($urandom_range(0, 7) == 0) addr = addr | ($urandom << (ADDR_W + 2));
            applyStimulus(1'($urandom_range(0, 1)), op, addr, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
